// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit for the EX stage: iterative shift-add multiply and
// restoring divide, one bit per cycle, with single-cycle divide special cases.
module ex_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q;
    logic        sign_a_q, sign_b_q;
    logic [31:0] mag_a_q, mag_b_q;
    logic [63:0] acc_q;
    logic [5:0]  count_q;
    logic [31:0] result_q;

    logic        is_div, signed_a, signed_b, sign_a_in, sign_b_in;
    logic        div_zero, div_ovf, special;
    logic [31:0] mag_a_in, mag_b_in, special_result;
    logic        accept, last;

    logic [32:0] mul_sum, div_shift, div_diff;
    logic [63:0] mul_next, div_next, acc_step, prod_signed;
    logic [31:0] quo, rem, final_result;

    // Operand decode for the instruction presented in IDLE
    always_comb begin
        is_div    = op[2];
        signed_a  = is_div ? ~op[0] : (op != 3'd3);
        signed_b  = is_div ? ~op[0] : ~op[1];
        sign_a_in = signed_a & rs1_data[31];
        sign_b_in = signed_b & rs2_data[31];
        mag_a_in  = sign_a_in ? -rs1_data : rs1_data;
        mag_b_in  = sign_b_in ? -rs2_data : rs2_data;
        div_zero  = is_div && (rs2_data == '0);
        div_ovf   = is_div && !op[0] && (rs1_data == 32'h8000_0000) && (rs2_data == '1);
        special   = div_zero | div_ovf;
        if (div_zero)
            special_result = op[1] ? rs1_data : '1;
        else
            special_result = op[1] ? '0 : 32'h8000_0000;
    end

    // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_b_q} : 33'd0);
        mul_next  = {mul_sum, acc_q[31:1]};
        div_shift = {acc_q[63:32], acc_q[31]};
        div_diff  = div_shift - {1'b0, mag_b_q};
        if (div_diff[32])
            div_next = {div_shift[31:0], acc_q[30:0], 1'b0};
        else
            div_next = {div_diff[31:0], acc_q[30:0], 1'b1};
        acc_step = (state_q == DIV) ? div_next : mul_next;
    end

    // Final sign correction is applied to the value produced by the last iteration
    always_comb begin
        prod_signed = (sign_a_q ^ sign_b_q) ? -acc_step : acc_step;
        quo         = (sign_a_q ^ sign_b_q) ? -acc_step[31:0] : acc_step[31:0];
        rem         = sign_a_q ? -acc_step[63:32] : acc_step[63:32];
        case (op_q)
            3'd0:                final_result = prod_signed[31:0];
            3'd1, 3'd2, 3'd3:    final_result = prod_signed[63:32];
            3'd4, 3'd5:          final_result = quo;
            default:             final_result = rem;
        endcase
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        accept  = 1'b1;
                        state_d = special ? DONE : (is_div ? DIV : MUL);
                    end
                end
                MUL, DIV: begin
                    if (count_q == 6'd31) begin
                        last    = 1'b1;
                        state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        stall  = ((state_q == IDLE) && start && !flush) || (state_q == MUL) || (state_q == DIV);
        done   = (state_q == DONE);
        result = result_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q     <= op;
                sign_a_q <= sign_a_in;
                sign_b_q <= sign_b_in;
                mag_a_q  <= mag_a_in;
                mag_b_q  <= mag_b_in;
                acc_q    <= {32'd0, mag_a_in};
                count_q  <= '0;
                if (special)
                    result_q <= special_result;
            end else if (!flush && (state_q == MUL || state_q == DIV)) begin
                acc_q   <= acc_step;
                count_q <= count_q + 6'd1;
                if (last)
                    result_q <= final_result;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv: arithmetic vectors, latency,
// special cases, flush, reset abort and held-start behaviour.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  op;
    logic [31:0] rs1_data, rs2_data;
    logic        stall, done;
    logic [31:0] result;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    ex_muldiv dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .flush    (flush),
        .stall    (stall),
        .done     (done),
        .result   (result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one op and follow it to completion; operands are scrambled after acceptance.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int unsigned exp_lat);
        int unsigned lat, stalls;
        op = o; rs1_data = a; rs2_data = b; start = 1'b1;
        #1;
        stalls = stall ? 1 : 0;
        tick;
        start = 1'b0;
        rs1_data = ~a;
        rs2_data = b ^ 32'h0000_1234;
        lat = 1;
        while (!done && lat < 64) begin
            stalls += stall ? 1 : 0;
            tick;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_lat));
        check({tag, "_res"}, result, exp_res);
        check({tag, "_stall_in_done"}, 32'(stall), 32'd0);
        tick;
        check({tag, "_done_drop"}, 32'(done), 32'd0);
        check({tag, "_hold"}, result, exp_res);
    endtask

    initial begin
        int unsigned dones;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; rs1_data = '0; rs2_data = '0;
        #3;
        check("rst_result", result, 32'h0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        tick;
        rst = 1'b0;
        tick;

        run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulh",   3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33);
        run_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
        run_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
        run_op("divu",   3'd5, 32'd100,        32'd7,         32'd14,        33);
        run_op("remu",   3'd7, 32'd100,        32'd7,         32'd2,         33);
        run_op("divu0",  3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem0",   3'd6, 32'd5,          32'd0,         32'd5,         1);
        run_op("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1);
        run_op("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);

        // flush during iteration 10 of a DIV
        op = 3'd4; rs1_data = 32'd100; rs2_data = 32'd3; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (10) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("flush_stall", 32'(stall), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            dones += done ? 1 : 0;
            tick;
        end
        check("flush_no_done", 32'(dones), 32'd0);
        check("flush_hold", result, 32'h8000_0000);

        // flush and start together in IDLE: start must be dropped
        op = 3'd0; rs1_data = 32'd2; rs2_data = 32'd2; start = 1'b1; flush = 1'b1;
        #1;
        check("flush_start_stall", 32'(stall), 32'd0);
        tick;
        start = 1'b0; flush = 1'b0;
        check("flush_start_idle", 32'(stall), 32'd0);

        run_op("mul34", 3'd0, 32'd3, 32'd4, 32'd12, 33);

        // reset during iteration 20 of a MUL
        op = 3'd0; rs1_data = 32'd9; rs2_data = 32'd9; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (20) tick;
        rst = 1'b1;
        #1;
        check("rst_mid_result", result, 32'h0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_stall", 32'(stall), 32'd0);
        tick;
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            dones += done ? 1 : 0;
            tick;
        end
        check("rst_no_done", 32'(dones), 32'd0);
        check("rst_idle_stall", 32'(stall), 32'd0);

        // start held high through the whole op and its DONE cycle
        op = 3'd0; rs1_data = 32'd5; rs2_data = 32'd6; start = 1'b1;
        tick;
        dones = 0;
        for (int i = 0; i < 40 && !done; i++) tick;
        dones += done ? 1 : 0;
        check("held_res", result, 32'd30);
        tick;
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            dones += done ? 1 : 0;
            tick;
        end
        check("held_one_done", 32'(dones), 32'd1);
        check("held_idle_stall", 32'(stall), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
